// File: rtl/data_sram_responder_pkg.sv
// Shared definitions for the data-side SRAM responder.
//  - dsram_state_t : responder FSM encodings (2 bits)
//  - STOP / NO_STOP: stall-request levels driven towards CTRL
//  - is_misaligned : byte-lane / address legality check, used only when the
//                    design is built with DSRAM_MISALIGN_CHK_EN defined
package data_sram_responder_pkg;

  typedef enum logic [1:0] {
    DSRAM_IDLE = 2'b00,
    DSRAM_WAIT = 2'b01,
    DSRAM_RESP = 2'b10
  } dsram_state_t;

  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  localparam int DATA_W = 32;
  localparam int LANES  = 4;

  // Legal lane patterns are single bytes, aligned halfwords and full words.
  // Reads (wen == 0) and full words need a word-aligned address; halfwords
  // need an even address; single bytes can sit anywhere.
  function automatic logic is_misaligned(input logic [3:0] wen,
                                         input logic [1:0] addr_lo);
    logic bad;
    case (wen)
      4'b0000, 4'b1111:                   bad = (addr_lo != 2'b00);
      4'b0011, 4'b1100:                   bad = addr_lo[0];
      4'b0001, 4'b0010, 4'b0100, 4'b1000: bad = 1'b0;
      default:                            bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/data_sram_responder_dsram_bank.sv
// dsram_bank: word-organised RAM built from four byte-lane arrays.
// Ports:
//  clk    in  1           write clock
//  we     in  4           per-lane write enables (lane i = bits 8i+7:8i)
//  waddr  in  DEPTH_LOG2  word write index
//  wdata  in  32          write data
//  raddr  in  DEPTH_LOG2  word read index
//  rdata  out 32          asynchronous read data
// Contents are never reset.
module dsram_bank
  import data_sram_responder_pkg::*;
#(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic [LANES-1:0]      we,
  input  logic [DEPTH_LOG2-1:0] waddr,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [DEPTH_LOG2-1:0] raddr,
  output logic [DATA_W-1:0]     rdata
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      logic [7:0] mem [DEPTH];

      always_ff @(posedge clk) begin
        if (we[gi]) begin
          mem[waddr] <= wdata[8*gi +: 8];
        end
      end

      // Combinational read: the top level registers the result itself so the
      // data lines up with the MEM stage sampling point.
      assign rdata[8*gi +: 8] = mem[raddr];
    end
  endgenerate

endmodule

// File: rtl/data_sram_responder.sv
// data_sram_responder: memory end of the data_sram_* interface. EX drives the
// request, MEM consumes data_sram_rdata, CTRL receives stallreq_for_mem.
// Parameters:
//  DEPTH_LOG2   word-address bits (RAM = 2**DEPTH_LOG2 x 32 bit)
//  WAIT_CYCLES  extra wait states per access (0..15)
// Ports:
//  clk               in  1   clock, posedge
//  resetn            in  1   asynchronous active-low reset
//  data_sram_en      in  1   access request
//  data_sram_wen     in  4   byte write enables, 0000 = read
//  data_sram_addr    in  32  byte address, word index = addr[DEPTH_LOG2+1:2]
//  data_sram_wdata   in  32  write data
//  data_sram_rdata   out 32  registered read data
//  stallreq_for_mem  out 1   stall request while an access is pending
//  misalign_err      out 1   sticky misalignment flag
// Build option: define DSRAM_MISALIGN_CHK_EN to enable misalignment checking
// (misaligned writes are dropped, misaligned reads return zero, misalign_err
// latches). Without it every access proceeds and misalign_err is tied low.
module data_sram_responder
  import data_sram_responder_pkg::*;
#(
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_CYCLES = 0
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              data_sram_en,
  input  logic [LANES-1:0]  data_sram_wen,
  input  logic [31:0]       data_sram_addr,
  input  logic [DATA_W-1:0] data_sram_wdata,
  output logic [DATA_W-1:0] data_sram_rdata,
  output logic              stallreq_for_mem,
  output logic              misalign_err
);

  localparam bit         NO_WAIT  = (WAIT_CYCLES == 0);
  localparam logic [3:0] CNT_LAST = NO_WAIT ? 4'd0 : 4'(WAIT_CYCLES - 1);

  dsram_state_t state_reg, state_next;
  logic [3:0]   count_reg, count_next;

  // Captured request, used when the access completes after wait states.
  logic [DEPTH_LOG2-1:0] pend_idx_reg;
  logic [LANES-1:0]      pend_wen_reg;
  logic [DATA_W-1:0]     pend_wdata_reg;
  logic                  pend_mis_reg;

  logic [DATA_W-1:0] rdata_reg;

  logic                  accept;
  logic                  last_wait;
  logic                  commit;
  logic                  acc_mis;
  logic [DEPTH_LOG2-1:0] req_idx;
  logic [DEPTH_LOG2-1:0] cur_idx;
  logic [LANES-1:0]      cur_wen;
  logic [DATA_W-1:0]     cur_wdata;
  logic                  cur_mis;
  logic [LANES-1:0]      bank_we;
  logic [DATA_W-1:0]     bank_rdata;
  logic                  stall_req;

  // Upper address bits alias onto the RAM; the byte offset only matters to
  // the optional alignment check.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{data_sram_addr[31:DEPTH_LOG2+2], data_sram_addr[1:0]};

  assign req_idx = data_sram_addr[DEPTH_LOG2+1:2];

`ifdef DSRAM_MISALIGN_CHK_EN
  assign acc_mis = is_misaligned(data_sram_wen, data_sram_addr[1:0]);
`else
  assign acc_mis = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg <= DSRAM_IDLE;
      count_reg <= 4'd0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state. With no wait states the FSM never leaves IDLE and each
  // access completes at its accept edge.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    accept     = (state_reg == DSRAM_IDLE) && data_sram_en;
    last_wait  = (state_reg == DSRAM_WAIT) && (count_reg == CNT_LAST);

    case (state_reg)
      DSRAM_IDLE: begin
        count_next = 4'd0;
        if (accept && !NO_WAIT) begin
          state_next = DSRAM_WAIT;
        end
      end
      DSRAM_WAIT: begin
        if (count_reg == CNT_LAST) begin
          state_next = DSRAM_RESP;
          count_next = 4'd0;
        end else begin
          count_next = count_reg + 4'd1;
        end
      end
      DSRAM_RESP: begin
        // Requests here are ignored; the held EX request is re-seen in IDLE.
        state_next = DSRAM_IDLE;
      end
      default: begin
        state_next = DSRAM_IDLE;
        count_next = 4'd0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Select which request completes this cycle: the live bus for zero-wait
  // builds, the captured request at the end of WAIT otherwise.
  // ---------------------------------------------------------------------------
  always_comb begin
    cur_idx   = req_idx;
    cur_wen   = data_sram_wen;
    cur_wdata = data_sram_wdata;
    cur_mis   = acc_mis;
    commit    = accept;
    if (!NO_WAIT) begin
      cur_idx   = pend_idx_reg;
      cur_wen   = pend_wen_reg;
      cur_wdata = pend_wdata_reg;
      cur_mis   = pend_mis_reg;
      commit    = last_wait;
    end
  end

  assign bank_we = (commit && !cur_mis) ? cur_wen : '0;

  dsram_bank #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_bank (
    .clk   (clk),
    .we    (bank_we),
    .waddr (cur_idx),
    .wdata (cur_wdata),
    .raddr (cur_idx),
    .rdata (bank_rdata)
  );

  // ---------------------------------------------------------------------------
  // Pending request capture and read-data register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pend_idx_reg   <= '0;
      pend_wen_reg   <= '0;
      pend_wdata_reg <= '0;
      pend_mis_reg   <= 1'b0;
    end else if (accept) begin
      pend_idx_reg   <= req_idx;
      pend_wen_reg   <= data_sram_wen;
      pend_wdata_reg <= data_sram_wdata;
      pend_mis_reg   <= acc_mis;
    end
  end

  // Only completed reads update rdata; writes leave the last read value.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rdata_reg <= '0;
    end else if (commit && (cur_wen == '0)) begin
      rdata_reg <= cur_mis ? '0 : bank_rdata;
    end
  end

  assign data_sram_rdata = rdata_reg;

  // Stall covers the accept cycle (combinationally) and all of WAIT. It is
  // gated by resetn so it drops the instant reset is asserted, even if EX is
  // still holding its request.
  assign stall_req        = resetn && !NO_WAIT &&
                            (accept || (state_reg == DSRAM_WAIT));
  assign stallreq_for_mem = stall_req ? STOP : NO_STOP;

`ifdef DSRAM_MISALIGN_CHK_EN
  logic misalign_err_reg;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      misalign_err_reg <= 1'b0;
    end else if (accept && acc_mis) begin
      misalign_err_reg <= 1'b1;
    end
  end

  assign misalign_err = misalign_err_reg;
`else
  assign misalign_err = 1'b0;
`endif

endmodule

// File: tb/tb_data_sram_responder.sv
// Directed bench for data_sram_responder: one zero-wait instance and one
// instance with three wait states, sharing clock and reset.
module tb_data_sram_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic resetn;

  logic        en0, stall0, mis0;
  logic [3:0]  wen0;
  logic [31:0] addr0, wdata0, rdata0;

  logic        en3, stall3, mis3;
  logic [3:0]  wen3;
  logic [31:0] addr3, wdata3, rdata3;

`ifdef DSRAM_MISALIGN_CHK_EN
  localparam logic [31:0] EXP_MIS    = 32'd1;
  localparam logic [31:0] EXP_WORD0  = 32'hA5A5_A5A5;
  localparam logic [31:0] EXP_MISRD  = 32'h0000_0000;
`else
  localparam logic [31:0] EXP_MIS    = 32'd0;
  localparam logic [31:0] EXP_WORD0  = 32'hDEAD_BEEF;
  localparam logic [31:0] EXP_MISRD  = 32'hDEAD_BEEF;
`endif

  data_sram_responder #(
    .DEPTH_LOG2  (10),
    .WAIT_CYCLES (0)
  ) u_w0 (
    .clk              (clk),
    .resetn           (resetn),
    .data_sram_en     (en0),
    .data_sram_wen    (wen0),
    .data_sram_addr   (addr0),
    .data_sram_wdata  (wdata0),
    .data_sram_rdata  (rdata0),
    .stallreq_for_mem (stall0),
    .misalign_err     (mis0)
  );

  data_sram_responder #(
    .DEPTH_LOG2  (10),
    .WAIT_CYCLES (3)
  ) u_w3 (
    .clk              (clk),
    .resetn           (resetn),
    .data_sram_en     (en3),
    .data_sram_wen    (wen3),
    .data_sram_addr   (addr3),
    .data_sram_wdata  (wdata3),
    .data_sram_rdata  (rdata3),
    .stallreq_for_mem (stall3),
    .misalign_err     (mis3)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
    $display("[TB] %s: observed %08h expected %08h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One access on the 3-wait-state instance, EX holding the request while
  // stalled. Stall must be high in cycles 1..4 and low in cycle 5 (RESP).
  task automatic w3_access(input logic [3:0] wen, input logic [31:0] addr,
                           input logic [31:0] wdata, input string tag,
                           input logic chk_rd, input logic [31:0] exp_rd);
    en3    = 1'b1;
    wen3   = wen;
    addr3  = addr;
    wdata3 = wdata;
    #1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("%s_stall_c%0d", tag, i + 1), {31'b0, stall3}, 32'd1);
      tick();
    end
    check($sformatf("%s_stall_c5", tag), {31'b0, stall3}, 32'd0);
    if (chk_rd) begin
      check($sformatf("%s_rdata_c5", tag), rdata3, exp_rd);
    end
    en3 = 1'b0;
    tick();
  endtask

  initial begin
    resetn = 1'b0;
    en0 = 1'b0; wen0 = 4'h0; addr0 = 32'h0; wdata0 = 32'h0;
    en3 = 1'b0; wen3 = 4'h0; addr3 = 32'h0; wdata3 = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rdata0", rdata0, 32'h0);
    check("rst_stall0", {31'b0, stall0}, 32'd0);
    check("rst_mis0",   {31'b0, mis0},   32'd0);
    check("rst_rdata3", rdata3, 32'h0);
    check("rst_stall3", {31'b0, stall3}, 32'd0);
    check("rst_mis3",   {31'b0, mis3},   32'd0);
    resetn = 1'b1;
    tick();

    // Zero-wait: full write then back-to-back read of the same word.
    en0 = 1'b1; wen0 = 4'hF; addr0 = 32'h10; wdata0 = 32'h1234_5678;
    #1;
    check("w0_wr_stall", {31'b0, stall0}, 32'd0);
    tick();
    wen0 = 4'h0; addr0 = 32'h10;
    #1;
    check("w0_rd_stall", {31'b0, stall0}, 32'd0);
    check("w0_wr_keeps_rdata", rdata0, 32'h0);
    tick();
    en0 = 1'b0;
    check("w0_raw_rdata", rdata0, 32'h1234_5678);

    // Partial write of lane 1 only.
    en0 = 1'b1; wen0 = 4'b0010; addr0 = 32'h10; wdata0 = 32'h0000_AB00;
    tick();
    wen0 = 4'h0;
    tick();
    en0 = 1'b0;
    check("w0_partial", rdata0, 32'h1234_AB78);

    // Upper address bits alias.
    en0 = 1'b1; wen0 = 4'hF; addr0 = 32'h1000_0004; wdata0 = 32'h0000_0011;
    tick();
    wen0 = 4'h0; addr0 = 32'h0000_0004;
    tick();
    en0 = 1'b0;
    check("w0_alias", rdata0, 32'h0000_0011);
    tick();
    check("w0_hold_idle", rdata0, 32'h0000_0011);
    en0 = 1'b1; wen0 = 4'hF; addr0 = 32'h8; wdata0 = 32'hFFFF_FFFF;
    tick();
    en0 = 1'b0;
    check("w0_hold_after_wr", rdata0, 32'h0000_0011);

    // Misalignment handling.
    en0 = 1'b1; wen0 = 4'hF; addr0 = 32'h0; wdata0 = 32'hA5A5_A5A5;
    tick();
    check("w0_aligned_no_err", {31'b0, mis0}, 32'd0);
    addr0 = 32'h2; wdata0 = 32'hDEAD_BEEF;
    tick();
    en0 = 1'b0;
    check("w0_mis_flag", {31'b0, mis0}, EXP_MIS);
    en0 = 1'b1; wen0 = 4'h0; addr0 = 32'h0;
    tick();
    en0 = 1'b0;
    check("w0_mis_wr_suppressed", rdata0, EXP_WORD0);
    check("w0_mis_sticky", {31'b0, mis0}, EXP_MIS);
    en0 = 1'b1; wen0 = 4'h0; addr0 = 32'h2;
    tick();
    en0 = 1'b0;
    check("w0_mis_read", rdata0, EXP_MISRD);

    // Three wait states.
    w3_access(4'hF, 32'h20, 32'hCAFE_BABE, "w3_wr20", 1'b0, 32'h0);
    w3_access(4'h0, 32'h20, 32'h0,         "w3_rd20", 1'b1, 32'hCAFE_BABE);
    check("w3_idle_stall", {31'b0, stall3}, 32'd0);
    check("w3_idle_hold", rdata3, 32'hCAFE_BABE);
    w3_access(4'hF, 32'h30, 32'h0BAD_F00D, "w3_wr30", 1'b0, 32'h0);
    check("w3_wr_keeps_rdata", rdata3, 32'hCAFE_BABE);

    // Reset in the middle of WAIT drops the pending write.
    en3 = 1'b1; wen3 = 4'hF; addr3 = 32'h30; wdata3 = 32'h5555_5555;
    #1;
    check("w3_abort_stall_c1", {31'b0, stall3}, 32'd1);
    tick();
    tick();
    check("w3_abort_stall_wait", {31'b0, stall3}, 32'd1);
    resetn = 1'b0;
    #1;
    check("w3_abort_stall_rst", {31'b0, stall3}, 32'd0);
    check("w3_abort_rdata_rst", rdata3, 32'h0);
    check("w0_rst_clears_mis", {31'b0, mis0}, 32'd0);
    en3 = 1'b0;
    tick();
    resetn = 1'b1;
    tick();
    w3_access(4'h0, 32'h30, 32'h0, "w3_rd30", 1'b1, 32'h0BAD_F00D);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
